// File: rtl/register_file_write_scheduler_pkg.sv
// Shared types for the register-file write scheduler: request and write-port structs.
// The write-port struct mirrors the register file's write fields so the two connect directly.
package PkgRegWriteSched;

  localparam int NUM_REQ  = 3;
  localparam int SEL_W    = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic              en;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wport_t;

endpackage

// File: rtl/register_file_write_scheduler_rr_arbiter_3.sv
// Three-way round-robin arbiter: combinational one-hot grant, search starts after the last grant.
// The pointer moves only when a grant is issued; it resets to 2 so requester 0 wins first.
module rr_arbiter_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] grant
);

  logic [1:0] last;

  always_comb begin
    grant = 3'b000;
    case (last)
      2'd0: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd1: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  // Every grant is a transfer, since grants only go to valid requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd2;
    end else if (grant[0]) begin
      last <= 2'd0;
    end else if (grant[1]) begin
      last <= 2'd1;
    end else if (grant[2]) begin
      last <= 2'd2;
    end
  end

endmodule

// File: rtl/register_file_write_scheduler.sv
// Arbitrates three writeback requesters onto one registered register-file write port (grant in N,
// write in N+1) and keeps a per-register pending-write scoreboard that answers decode busy queries.
module register_file_write_scheduler #(
  parameter int NUM_REQ  = PkgRegWriteSched::NUM_REQ,
  parameter int NUM_REGS = PkgRegWriteSched::NUM_REGS,
  parameter int DATA_W   = PkgRegWriteSched::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             in_req_valid,
  input  logic [NUM_REQ-1:0][3:0]        in_req_sel,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] in_req_data,
  output logic [NUM_REQ-1:0]             out_req_ready,
  input  logic                           in_reserve_en,
  input  logic [3:0]                     in_reserve_sel,
  input  logic [3:0]                     in_query_sel_ra,
  input  logic [3:0]                     in_query_sel_rb,
  input  logic [3:0]                     in_query_sel_rc,
  output logic                           out_busy_ra,
  output logic                           out_busy_rb,
  output logic                           out_busy_rc,
  output logic                           out_write_en,
  output logic [3:0]                     out_write_sel,
  output logic [DATA_W-1:0]              out_write_data,
  output logic                           out_err
);

  import PkgRegWriteSched::*;

  req_t   win;
  wport_t wport;
  logic [NUM_REGS-1:0][1:0] cnt;
  logic [NUM_REGS-1:0]      err_hit;

  rr_arbiter_3 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (in_req_valid),
    .grant (out_req_ready)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_req_ready[i]) begin
        win.valid = 1'b1;
        win.sel   = in_req_sel[i];
        win.data  = in_req_data[i];
      end
    end
  end

  // A grant to r0 is accepted but never turns into a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wport <= '0;
    end else begin
      wport.en <= win.valid && (win.sel != '0);
      if (win.valid) begin
        wport.sel  <= win.sel;
        wport.data <= win.data;
      end
    end
  end

  assign out_write_en   = wport.en;
  assign out_write_sel  = wport.sel;
  assign out_write_data = wport.data;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign cnt[r]     = 2'd0;
      assign err_hit[r] = 1'b0;
    end else begin : g_reg
      logic       res;
      logic       com;
      logic [1:0] cnt_q;

      assign res = in_reserve_en && (in_reserve_sel == SEL_W'(r));
      assign com = wport.en && (wport.sel == SEL_W'(r));
      assign err_hit[r] = (res && !com && (cnt_q == 2'd3)) ||
                          (com && !res && (cnt_q == 2'd0));
      assign cnt[r] = cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= 2'd0;
        end else if (res && !com && (cnt_q != 2'd3)) begin
          cnt_q <= cnt_q + 2'd1;
        end else if (com && !res && (cnt_q != 2'd0)) begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= 1'b0;
    end else if (|err_hit) begin
      out_err <= 1'b1;
    end
  end

  // The last outstanding write being committed this cycle is forwarded by the register file.
  function automatic logic busy_of(input logic [3:0] s);
    busy_of = (s != 4'd0) && (cnt[s] != 2'd0) &&
              !(wport.en && (wport.sel == s) && (cnt[s] == 2'd1));
  endfunction

  assign out_busy_ra = busy_of(in_query_sel_ra);
  assign out_busy_rb = busy_of(in_query_sel_rb);
  assign out_busy_rc = busy_of(in_query_sel_rc);

endmodule

// File: tb/tb_register_file_write_scheduler.sv
// Directed and random checks of the write scheduler against a pending-count model of the register file.
module tb_register_file_write_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       req_valid;
  logic [2:0][3:0]  req_sel;
  logic [2:0][31:0] req_data;
  logic [2:0]       ready;
  logic             reserve_en;
  logic [3:0]       reserve_sel, qa, qb, qc;
  logic             ba, bb, bc, we, err;
  logic [3:0]       wsel;
  logic [31:0]      wdata;

  int total = 0;
  int bad = 0;
  bit auto_drop = 1'b1;

  int          m_last;
  bit          m_we;
  int          m_wsel;
  logic [31:0] m_wdata;
  int          m_cnt[16];
  bit          m_err;

  logic [2:0] rr_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  register_file_write_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_req_valid    (req_valid),
    .in_req_sel      (req_sel),
    .in_req_data     (req_data),
    .out_req_ready   (ready),
    .in_reserve_en   (reserve_en),
    .in_reserve_sel  (reserve_sel),
    .in_query_sel_ra (qa),
    .in_query_sel_rb (qb),
    .in_query_sel_rc (qc),
    .out_busy_ra     (ba),
    .out_busy_rb     (bb),
    .out_busy_rc     (bc),
    .out_write_en    (we),
    .out_write_sel   (wsel),
    .out_write_data  (wdata),
    .out_err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_busy(input int s);
    int eff;
    if (s == 0) return 1'b0;
    eff = m_cnt[s] - ((m_we && m_wsel == s) ? 1 : 0);
    return eff > 0;
  endfunction

  task automatic model_reset();
    m_last = 2;
    m_we = 1'b0;
    m_wsel = 0;
    m_wdata = 32'd0;
    m_err = 1'b0;
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
  endtask

  task automatic settle();
    int g;
    @(negedge clk);
    g = model_grant();
    chk("ready", 32'(ready), (g < 0) ? 32'd0 : 32'(1 << g));
    chk("write_en", 32'(we), 32'(m_we));
    if (m_we) begin
      chk("write_sel", 32'(wsel), 32'(m_wsel));
      chk("write_data", wdata, m_wdata);
    end
    chk("busy_ra", 32'(ba), 32'(model_busy(int'(qa))));
    chk("busy_rb", 32'(bb), 32'(model_busy(int'(qb))));
    chk("busy_rc", 32'(bc), 32'(model_busy(int'(qc))));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic advance();
    int g;
    int d;
    int nc[16];
    bit ne;
    logic [3:0]  gs;
    logic [31:0] gd;
    g = model_grant();
    gs = 4'd0;
    gd = 32'd0;
    if (g >= 0) begin
      gs = req_sel[g];
      gd = req_data[g];
    end
    ne = m_err;
    nc[0] = 0;
    for (int r = 1; r < 16; r++) begin
      d = 0;
      if (reserve_en && int'(reserve_sel) == r) d++;
      if (m_we && m_wsel == r) d--;
      nc[r] = m_cnt[r];
      if (d > 0) begin
        if (m_cnt[r] == 3) ne = 1'b1; else nc[r] = m_cnt[r] + 1;
      end else if (d < 0) begin
        if (m_cnt[r] == 0) ne = 1'b1; else nc[r] = m_cnt[r] - 1;
      end
    end
    @(posedge clk);
    m_cnt = nc;
    m_err = ne;
    if (g >= 0) begin
      m_we = (gs != 4'd0);
      m_wsel = int'(gs);
      m_wdata = gd;
      m_last = g;
    end else begin
      m_we = 1'b0;
    end
    #1;
    if (auto_drop && g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 3'b000;
    req_sel = '0;
    req_data = '0;
    reserve_en = 1'b0;
    reserve_sel = 4'd0;
    qa = 4'd0;
    qb = 4'd0;
    qc = 4'd0;
    auto_drop = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_write_en", 32'(we), 32'd0);
    chk("rst_write_sel", 32'(wsel), 32'd0);
    chk("rst_write_data", wdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;

    // Single request from requester 1, destination reserved in the same cycle.
    reserve_en = 1'b1; reserve_sel = 4'd5; qa = 4'd5;
    req_valid[1] = 1'b1; req_sel[1] = 4'd5; req_data[1] = 32'hDEADBEEF;
    settle();
    chk("single_ready", 32'(ready), 32'b010);
    advance();
    reserve_en = 1'b0;
    settle();
    chk("single_we", 32'(we), 32'd1);
    chk("single_sel", 32'(wsel), 32'd5);
    chk("single_data", wdata, 32'hDEADBEEF);
    chk("single_busy_fwd", 32'(ba), 32'd0);
    advance();
    settle();
    advance();

    // Round-robin with all three continuously valid (r0 targets, so nothing commits).
    do_reset();
    auto_drop = 1'b0;
    req_valid = 3'b111;
    req_data[0] = $urandom; req_data[1] = $urandom; req_data[2] = $urandom;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_ready", 32'(ready), 32'(rr_exp[i]));
      chk("rr_r0_no_write", 32'(we), 32'd0);
      advance();
    end
    auto_drop = 1'b1;
    req_valid = 3'b000;

    // Scoreboard: two reservations of r7 drained by two writes.
    do_reset();
    reserve_en = 1'b1; reserve_sel = 4'd7; qa = 4'd7;
    settle(); advance();
    settle(); advance();
    reserve_en = 1'b0;
    req_valid = 3'b011;
    req_sel[0] = 4'd7; req_data[0] = 32'h1111_AAAA;
    req_sel[1] = 4'd7; req_data[1] = 32'h2222_BBBB;
    settle();
    chk("sb_busy_reserved", 32'(ba), 32'd1);
    advance();
    settle();
    chk("sb_busy_first_commit", 32'(ba), 32'd1);
    chk("sb_first_data", wdata, 32'h1111_AAAA);
    advance();
    settle();
    chk("sb_busy_last_commit", 32'(ba), 32'd0);
    chk("sb_second_data", wdata, 32'h2222_BBBB);
    advance();
    settle();
    chk("sb_busy_after", 32'(ba), 32'd0);
    chk("sb_err", 32'(err), 32'd0);
    advance();

    // r0: reserve and write are both no-ops.
    do_reset();
    reserve_en = 1'b1; reserve_sel = 4'd0;
    req_valid[0] = 1'b1; req_sel[0] = 4'd0; req_data[0] = 32'h0BAD_0BAD;
    settle();
    chk("r0_ready", 32'(ready), 32'b001);
    chk("r0_busy_res", 32'(ba), 32'd0);
    advance();
    reserve_en = 1'b0;
    settle();
    chk("r0_no_write", 32'(we), 32'd0);
    chk("r0_busy", 32'(bb), 32'd0);
    chk("r0_err", 32'(err), 32'd0);
    advance();

    // Reserve r3 four times: saturates at 3 and flags an error.
    do_reset();
    reserve_en = 1'b1; reserve_sel = 4'd3; qa = 4'd3;
    for (int i = 0; i < 4; i++) begin
      settle();
      advance();
    end
    reserve_en = 1'b0;
    settle();
    chk("sat_err", 32'(err), 32'd1);
    chk("sat_busy", 32'(ba), 32'd1);
    for (int k = 0; k < 3; k++) begin
      req_valid[2] = 1'b1; req_sel[2] = 4'd3; req_data[2] = $urandom;
      advance();
      settle();
      if (k == 1) chk("sat_busy_held", 32'(ba), 32'd1);
    end
    advance();
    settle();
    chk("sat_drained", 32'(ba), 32'd0);
    advance();

    // Commit to r4 with nothing reserved.
    do_reset();
    req_valid[0] = 1'b1; req_sel[0] = 4'd4; req_data[0] = 32'h4444_4444;
    settle(); advance();
    settle();
    chk("empty_commit_we", 32'(we), 32'd1);
    chk("empty_commit_err_early", 32'(err), 32'd0);
    advance();
    settle();
    chk("empty_commit_err", 32'(err), 32'd1);
    advance();

    // Asynchronous reset in the middle of a granted transfer with a write in flight.
    do_reset();
    reserve_en = 1'b1; reserve_sel = 4'd5; qa = 4'd5;
    settle(); advance();
    settle(); advance();
    reserve_en = 1'b0;
    req_valid = 3'b001; req_sel[0] = 4'd5; req_data[0] = 32'h5555_0000;
    settle(); advance();
    req_valid[1] = 1'b1; req_sel[1] = 4'd5; req_data[1] = 32'h5555_1111;
    settle();
    chk("arst_inflight_we", 32'(we), 32'd1);
    chk("arst_inflight_ready", 32'(ready), 32'b010);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_sel", 32'(wsel), 32'd0);
    chk("arst_data", wdata, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_busy", 32'(ba), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_no_write", 32'(we), 32'd0);
    req_valid = 3'b111;
    req_sel = '0;
    rst_n = 1'b1;
    settle();
    chk("arst_prio", 32'(ready), 32'b001);
    advance();
    req_valid = 3'b000;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_sel[i] = 4'($urandom_range(0, 15));
          req_data[i] = $urandom;
        end
      end
      reserve_en = ($urandom_range(0, 2) == 0);
      reserve_sel = 4'($urandom_range(0, 15));
      qa = 4'($urandom_range(0, 15));
      qb = 4'($urandom_range(0, 15));
      qc = 4'($urandom_range(0, 15));
      settle();
      advance();
    end
    req_valid = 3'b000;
    reserve_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_write_scheduler.md
# register_file_write_scheduler

Shares the single register file write port among three writeback requesters and tracks which registers have writes in flight. Requesters are ALU, load and multiply/divide. Round-robin arbitration drives registered write-port fields straight into the register file's `write_en`/`write_sel`/`write_data` inputs. A pending-write scoreboard answers the three read-select queries, and decode uses those answers to stall.

## Interface
- `NUM_REQ`, 3: writeback requesters, fixed at 3.
- `NUM_REGS`, 16: architectural registers; r0 is hardwired zero.
- `DATA_W`, 32: register data width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_req_valid`  in  3  per-requester write request.
- `in_req_sel`  in  3×4  per-requester destination register.
- `in_req_data`  in  3×DATA_W  per-requester write data.
- `out_req_ready`  out  3  one-hot grant, combinational, at most one bit set.
- `in_reserve_en`  in  1  decode issues an instruction that will write a register.
- `in_reserve_sel`  in  4  register being reserved.
- `in_query_sel_ra`, `in_query_sel_rb`, `in_query_sel_rc`  in  4 each  registers decode wants to read.
- `out_busy_ra`, `out_busy_rb`, `out_busy_rc`  out  1 each  queried register has an uncommitted write.
- `out_write_en`  out  1  to register file write enable; registered.
- `out_write_sel`  out  4  to register file write select; registered.
- `out_write_data`  out  DATA_W  to register file write data; registered.
- `out_err`  out  1  sticky scoreboard error.

## Operation
- **Handshake:** valid/ready.
  - A requester holds `valid`, `sel` and `data` stable until it sees `ready`.
  - A transfer happens in the cycle where both are high.
  - `ready` never depends on the requester's own `data`.
- **Arbitration:** round-robin over valid requesters.
  - The search starts at the requester after the last one granted.
  - The last-granted pointer resets to 2, so requester 0 has first priority after reset.
  - The pointer advances only on a transfer.
- **Request with sel == 0:** granted normally but commits nothing.
  - `out_write_en` stays 0 on the following cycle.
  - The scoreboard is unaffected.
- **Scoreboard:** one 2-bit pending counter per register; r0 is always 0.
  - Reserve (`in_reserve_en`, sel ≠ 0): counter +1.
  - Commit: counter −1 in the cycle `out_write_en` is high for that sel.
  - Reserve and commit on the same register in the same cycle: counter unchanged.
  - Reserve while the counter is 3, or commit while it is 0: counter held and `out_err` is set.
  - `out_err` clears only on reset.
- **Busy query:** `busy_x` = (counter[sel] ≠ 0), except:
  - sel == 0 is never busy;
  - the register currently being committed (`out_write_en` && `out_write_sel` == sel && counter == 1) reads not-busy, because the register file forwards its same-cycle write.
  - Busy is combinational from state and `in_query_sel_*`.

## Timing
- **Reset values:** `out_write_en`=0, `out_write_sel`=0, `out_write_data`=0, `out_err`=0, all counters 0, pointer=2.
- **Grant:** combinational in cycle N.
- **Write port:** write fields are registered and valid in cycle N+1. The register file stores the data at the end of N+1.
- **Scoreboard update:** the counter decrement is visible in cycle N+2.
- **Throughput:** one write per cycle. With several requesters continuously valid, each is granted once per 3 cycles.
- **Reset mid-operation:** all counters and in-flight write fields are cleared immediately.
  - The write registered for N+1 is dropped.
  - Requesters must re-issue after `rst_n` deasserts.
- **Idle:** no valid requester leaves `out_write_en`=0 and the pointer unchanged.

## Structure
- Shared package `PkgRegWriteSched`, which holds:
  - `NUM_REQ` and the register-select width (4);
  - a packed request struct {valid, sel, data};
  - a write-port struct mirroring the register file's write fields, so the output connects to its input struct directly.
- Sub-module `rr_arbiter_3`: pointer register plus one-hot grant logic, reusable for memory-port sharing.
- The scoreboard stays inline (16 counters via generate loop).

## Test plan
- **Single request:** after reset, req1 valid sel=5 data=0xDEADBEEF.
  - Cycle N: ready=3'b010.
  - Cycle N+1: write_en=1, sel=5, data=0xDEADBEEF.
- **Round-robin:** all three valid continuously.
  - Grants in order 001, 010, 100, 001.
  - Each requester is granted every 3 cycles.
- **Scoreboard:** reserve r7 twice, then two requests to r7.
  - busy_ra(sel=7) stays 1 until the commit cycle of the second write, where it reads 0.
  - It is 0 afterwards; out_err=0.
- **Error paths:**
  - Reserve r3 four times: out_err=1, counter stays 3.
  - Commit r4 with counter 0: out_err=1.
- **r0 handling:**
  - req0 sel=0: granted, write_en stays 0.
  - Reserve r0: busy on sel 0 always 0.
- **Async reset:** assert rst_n=0 mid-cycle during a granted transfer.
  - All outputs reach reset values before the next edge.
  - No write is issued.
  - After release, requester 0 has priority.
